matmul_tile_buffer_ctrl: RTL

//  Parametrised A/B/C tile-buffer controller for an NxN grid of BB_SIZE systolic matmul tiles.

---
 rtl/matmul_tile_buffer_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/matmul_tile_buffer_ctrl.sv
// Tile-buffer controller for an NxN systolic matmul grid. It owns the A/B/C single-port RAM banks,
// host write/read access, run sequencing (start/busy/done) and C-row capture, all on clk_mem.
module matmul_tile_buffer_ctrl #(
  parameter int DWIDTH    = 8,
  parameter int BB_SIZE   = 32,
  parameter int AWIDTH    = 7,
  parameter int NUM_TILES = 2,
  parameter int BWIDTH    = 1,
  parameter int C_ROWS    = 32
) (
  input  logic                                clk_mem,
  input  logic                                reset,
  input  logic                                host_wr_en,
  input  logic                                host_wr_sel,
  input  logic [BWIDTH-1:0]                   host_bank,
  input  logic [AWIDTH-1:0]                   host_addr,
  input  logic [BB_SIZE*DWIDTH-1:0]           host_wr_data,
  input  logic                                host_rd_req,
  output logic [BB_SIZE*DWIDTH-1:0]           host_rd_data,
  output logic                                host_rd_valid,
  output logic                                host_err,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                mm_start,
  input  logic                                mm_done,
  input  logic [NUM_TILES*AWIDTH-1:0]         mm_a_addr,
  input  logic [NUM_TILES*AWIDTH-1:0]         mm_b_addr,
  output logic [NUM_TILES*BB_SIZE*DWIDTH-1:0] mm_a_data,
  output logic [NUM_TILES*BB_SIZE*DWIDTH-1:0] mm_b_data,
  input  logic                                c_wr_valid,
  input  logic [NUM_TILES*BB_SIZE*DWIDTH-1:0] c_wr_data,
  output logic [1:0]                          o_dbg_state
);
  localparam int W     = BB_SIZE * DWIDTH;
  localparam int DEPTH = 2 ** AWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AWIDTH:0] LP_C_ROWS = (AWIDTH + 1)'(C_ROWS);
  localparam logic [BWIDTH:0] LP_NT     = (BWIDTH + 1)'(NUM_TILES);

  logic [1:0]             r_state;
  logic [AWIDTH:0]        r_c_beats;
  logic [AWIDTH:0]        w_beats_nxt;
  logic                   w_idle;
  logic                   w_cap;
  logic                   w_bank_ok;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_host_wr_idle;
  logic [NUM_TILES-1:0]   w_bank_oh;
  logic [W-1:0]           r_wr_data;
  logic                   r_c_we;
  logic [AWIDTH-1:0]      r_c_addr;
  logic [NUM_TILES*W-1:0] r_c_wdata;
  logic                   r_rd_v1;
  logic                   r_rd_v2;
  logic [AWIDTH-1:0]      r_rd_addr;
  logic [NUM_TILES-1:0]   r_rd_oh;
  logic [BWIDTH-1:0]      r_rd_bank1;
  logic [BWIDTH-1:0]      r_rd_bank2;
  logic [W-1:0]           r_rd_data;
  logic                   r_rd_valid;
  logic                   r_host_err;
  logic [W-1:0]           w_c_q [NUM_TILES];

  // Host strobes are single-cycle requests with no back-pressure: a request is either accepted
  // in the cycle it is presented or dropped and flagged on host_err; host_rd_valid/done are pulses.
  assign w_idle         = (r_state == S_IDLE);
  assign w_bank_ok      = ({1'b0, host_bank} < LP_NT);
  assign w_wr_ok        = host_wr_en && w_idle && w_bank_ok;
  assign w_rd_ok        = host_rd_req && !host_wr_en && w_idle && w_bank_ok;
  assign w_host_wr_idle = host_wr_en && w_idle;

  assign w_cap       = ((r_state == S_RUN) || (r_state == S_DRAIN)) && c_wr_valid &&
                       (r_c_beats < LP_C_ROWS);
  assign w_beats_nxt = w_cap ? (r_c_beats + (AWIDTH + 1)'(1)) : r_c_beats;

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign mm_start      = (r_state == S_RUN);
  assign o_dbg_state   = r_state;
  assign host_rd_data  = r_rd_data;
  assign host_rd_valid = r_rd_valid;
  assign host_err      = r_host_err;

  // RUN judges mm_done against the count including a coincident beat.
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_c_beats <= '0;
    end else begin
      r_c_beats <= w_beats_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_c_beats <= '0;
          end
        end
        S_RUN: begin
          if (mm_done) r_state <= (w_beats_nxt == LP_C_ROWS) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (r_c_beats == LP_C_ROWS) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      r_host_err <= 1'b0;
      r_wr_data  <= '0;
      r_c_we     <= 1'b0;
      r_c_addr   <= '0;
      r_c_wdata  <= '0;
      r_rd_v1    <= 1'b0;
      r_rd_v2    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_oh    <= '0;
      r_rd_bank1 <= '0;
      r_rd_bank2 <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if ((host_wr_en && !w_wr_ok) || (host_rd_req && !w_rd_ok)) r_host_err <= 1'b1;
      r_wr_data  <= host_wr_data;
      r_c_we     <= w_cap;
      r_c_addr   <= r_c_beats[AWIDTH-1:0];
      r_c_wdata  <= c_wr_data;
      r_rd_v1    <= w_rd_ok;
      r_rd_addr  <= host_addr;
      r_rd_oh    <= w_rd_ok ? w_bank_oh : '0;
      r_rd_bank1 <= host_bank;
      r_rd_v2    <= r_rd_v1;
      r_rd_bank2 <= r_rd_bank1;
      r_rd_valid <= r_rd_v2;
      if (r_rd_v2) r_rd_data <= w_c_q[r_rd_bank2];
    end
  end

  for (genvar k = 0; k < NUM_TILES; k++) begin : g_bank
    logic [W-1:0]      r_a_mem [DEPTH];
    logic [W-1:0]      r_b_mem [DEPTH];
    logic [W-1:0]      r_c_mem [DEPTH];
    logic [AWIDTH-1:0] r_a_addr;
    logic [AWIDTH-1:0] r_b_addr;
    logic              r_a_we;
    logic              r_b_we;
    logic [W-1:0]      r_a_q;
    logic [W-1:0]      r_b_q;
    logic [W-1:0]      r_c_q;
    logic [W-1:0]      r_a_out;
    logic [W-1:0]      r_b_out;

    assign w_bank_oh[k]           = (host_bank == BWIDTH'(k));
    assign w_c_q[k]               = r_c_q;
    assign mm_a_data[k*W +: W]    = r_a_out;
    assign mm_b_data[k*W +: W]    = r_b_out;

    // Each A/B bank has one address register shared by host writes and array reads.
    always_ff @(posedge clk_mem) begin
      if (reset) begin
        r_a_we   <= 1'b0;
        r_b_we   <= 1'b0;
        r_a_addr <= '0;
        r_b_addr <= '0;
        r_a_q    <= '0;
        r_b_q    <= '0;
        r_c_q    <= '0;
        r_a_out  <= '0;
        r_b_out  <= '0;
      end else begin
        r_a_we   <= w_wr_ok && !host_wr_sel && w_bank_oh[k];
        r_b_we   <= w_wr_ok && host_wr_sel && w_bank_oh[k];
        r_a_addr <= w_host_wr_idle ? host_addr : mm_a_addr[k*AWIDTH +: AWIDTH];
        r_b_addr <= w_host_wr_idle ? host_addr : mm_b_addr[k*AWIDTH +: AWIDTH];
        if (!r_a_we) r_a_q <= r_a_mem[r_a_addr];
        if (!r_b_we) r_b_q <= r_b_mem[r_b_addr];
        if (!r_c_we && r_rd_oh[k]) r_c_q <= r_c_mem[r_rd_addr];
        r_a_out  <= r_a_q;
        r_b_out  <= r_b_q;
      end
    end

    always_ff @(posedge clk_mem) begin
      if (r_a_we) r_a_mem[r_a_addr] <= r_wr_data;
      if (r_b_we) r_b_mem[r_b_addr] <= r_wr_data;
      if (r_c_we) r_c_mem[r_c_addr] <= r_c_wdata[k*W +: W];
    end
  end

endmodule
